// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching dispatch controller: FSM state
// encoding and default geometry constants.
package sme_pkg;

  localparam int SME_NUM_PE = 4;
  localparam int SME_STR_AW = 8;
  localparam int SME_PAT_AW = 5;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CALC     = 3'd1;
  localparam logic [2:0] ST_DISPATCH = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_REDUCE   = 3'd4;
  localparam logic [2:0] ST_OUT      = 3'd5;

endpackage

// File: rtl/sme_min_tree.sv
// Combinational minimum tree over per-PE match results. Key is {!match, idx},
// so matching PEs sort first and the lower PE index wins on equal keys.
module sme_min_tree
  import sme_pkg::*;
#(
  parameter int N  = SME_NUM_PE,
  parameter int AW = SME_STR_AW
) (
  input  logic [N-1:0]    match_i,
  input  logic [N*AW-1:0] idx_i,
  output logic            match_o,
  output logic [AW-1:0]   idx_o
);

  // Heap layout: leaves at N..2N-1, node i is the minimum of nodes 2i and 2i+1.
  logic [AW:0] key_s [1:2*N-1];

  // Reduce leaf keys level by level up to the root.
  always_comb begin
    for (int i = 1; i < 2 * N; i++) begin
      key_s[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      key_s[N+i] = {~match_i[i], idx_i[i*AW +: AW]};
    end
    for (int i = N - 1; i >= 1; i--) begin
      key_s[i] = (key_s[2*i] <= key_s[2*i+1]) ? key_s[2*i] : key_s[2*i+1];
    end
    match_o = ~key_s[1][AW];
    idx_o   = match_o ? key_s[1][AW-1:0] : '0;
  end

endmodule

// File: rtl/sme_dispatch_ctrl.sv
// Splits a string search across NUM_PE matching engines with pattern overlap,
// collects their results and reports the earliest match. Define
// SME_WATCHDOG_EN to bound the WAIT state and add the o_timeout output.
module sme_dispatch_ctrl
  import sme_pkg::*;
#(
  parameter int NUM_PE   = SME_NUM_PE,
  parameter int STR_AW   = SME_STR_AW,
  parameter int PAT_AW   = SME_PAT_AW,
  parameter int WDOG_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [STR_AW-1:0]        str_last_idx,
  input  logic [PAT_AW-1:0]        pat_last_idx,
  output logic                     busy,
  output logic                     pe_valid,
  output logic [NUM_PE-1:0]        pe_en,
  output logic [NUM_PE*STR_AW-1:0] pe_start_idx,
  output logic [NUM_PE*STR_AW-1:0] pe_end_idx,
  input  logic [NUM_PE-1:0]        pe_done,
  input  logic [NUM_PE-1:0]        pe_match,
  input  logic [NUM_PE*STR_AW-1:0] pe_match_idx,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     o_match,
  output logic [STR_AW-1:0]        o_match_idx
`ifdef SME_WATCHDOG_EN
  ,
  output logic                     o_timeout
`endif
);

  localparam int LG = $clog2(NUM_PE);
  localparam int W  = STR_AW + 1;

  if (NUM_PE < 2 || WDOG_CYC < 1) begin : g_param_chk
    $error("sme_dispatch_ctrl: NUM_PE must be >= 2 and WDOG_CYC >= 1");
  end

  logic [2:0]               state_q, state_d;
  logic [W-1:0]             len_q, part_q, len_s, last_s, raw_s, hi_s;
  logic [PAT_AW-1:0]        pat_q;
  logic                     busy_q, pe_valid_q, o_valid_q, o_match_q;
  logic [STR_AW-1:0]        o_idx_q;
  logic [NUM_PE-1:0]        en_q, calc_en_s;
  logic [NUM_PE*STR_AW-1:0] start_q, end_q, calc_start_s, calc_end_s;
  logic [NUM_PE-1:0]        done_q, done_d, hit_q, hit_d;
  logic [NUM_PE*STR_AW-1:0] cidx_q, cidx_d;
  logic                     collect_s, all_done_s, wd_hit_s, red_match_s;
  logic [STR_AW-1:0]        red_idx_s;

  assign len_s = {1'b0, str_last_idx} + W'(1);

  // Per-PE ranges from the registered length/part; the last PE takes the remainder.
  always_comb begin
    calc_en_s    = '1;
    calc_start_s = '0;
    calc_end_s   = '0;
    last_s       = len_q - W'(1);
    raw_s        = '0;
    hi_s         = '0;
    if (part_q == '0) begin
      calc_en_s                 = NUM_PE'(1);
      calc_end_s[STR_AW-1:0]    = last_s[STR_AW-1:0];
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        calc_start_s[k*STR_AW +: STR_AW] = STR_AW'(k) * part_q[STR_AW-1:0];
        raw_s = W'(k + 1) * part_q - W'(1) + W'(pat_q);
        hi_s  = (k == NUM_PE - 1 || raw_s > last_s) ? last_s : raw_s;
        calc_end_s[k*STR_AW +: STR_AW] = hi_s[STR_AW-1:0];
      end
    end
  end

  assign collect_s = (state_q == ST_DISPATCH) || (state_q == ST_WAIT);

  // Sticky per-PE capture: only the first pulse of an enabled PE is kept.
  always_comb begin
    done_d = done_q;
    hit_d  = hit_q;
    cidx_d = cidx_q;
    if (state_q == ST_CALC) begin
      done_d = '0;
      hit_d  = '0;
      cidx_d = '0;
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        done_d[k] = done_q[k] | (collect_s & en_q[k] & pe_done[k]);
        hit_d[k]  = (collect_s && en_q[k] && pe_done[k] && !done_q[k]) ? pe_match[k] : hit_q[k];
        cidx_d[k*STR_AW +: STR_AW] = (collect_s && en_q[k] && pe_done[k] && !done_q[k])
                                   ? pe_match_idx[k*STR_AW +: STR_AW]
                                   : cidx_q[k*STR_AW +: STR_AW];
      end
    end
  end

  assign all_done_s = ((done_d & en_q) == en_q);

`ifdef SME_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] wd_q;
  logic          to_q, o_to_q;

  assign wd_hit_s  = (state_q == ST_WAIT) && (wd_q == CW'(WDOG_CYC - 1));
  assign o_timeout = o_to_q;

  // WAIT cycle counter and timeout flag, latched into the result at REDUCE.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q   <= '0;
      to_q   <= 1'b0;
      o_to_q <= 1'b0;
    end else begin
      wd_q   <= (state_q == ST_WAIT) ? wd_q + CW'(1) : '0;
      if (state_q == ST_CALC) to_q <= 1'b0;
      else if (wd_hit_s && !all_done_s) to_q <= 1'b1;
      if (state_q == ST_REDUCE) o_to_q <= to_q;
      else if (state_d != ST_OUT) o_to_q <= 1'b0;
    end
  end
`else
  assign wd_hit_s = 1'b0;
`endif

  // Controller next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = start ? ST_CALC : ST_IDLE;
      ST_CALC:     state_d = ST_DISPATCH;
      ST_DISPATCH: state_d = ST_WAIT;
      ST_WAIT:     state_d = (all_done_s || wd_hit_s) ? ST_REDUCE : ST_WAIT;
      ST_REDUCE:   state_d = ST_OUT;
      ST_OUT:      state_d = (o_valid_q && o_ready) ? ST_IDLE : ST_OUT;
      default:     state_d = ST_IDLE;
    endcase
  end

  sme_min_tree #(.N(NUM_PE), .AW(STR_AW)) u_min_tree (
    .match_i (hit_q & en_q),
    .idx_i   (cidx_q),
    .match_o (red_match_s),
    .idx_o   (red_idx_s)
  );

  // State, captured results and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      part_q     <= '0;
      pat_q      <= '0;
      busy_q     <= 1'b0;
      pe_valid_q <= 1'b0;
      en_q       <= '0;
      start_q    <= '0;
      end_q      <= '0;
      done_q     <= '0;
      hit_q      <= '0;
      cidx_q     <= '0;
      o_valid_q  <= 1'b0;
      o_match_q  <= 1'b0;
      o_idx_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != ST_IDLE);
      pe_valid_q <= (state_d == ST_DISPATCH);
      o_valid_q  <= (state_d == ST_OUT);
      done_q     <= done_d;
      hit_q      <= hit_d;
      cidx_q     <= cidx_d;
      if (state_q == ST_IDLE && start) begin
        len_q  <= len_s;
        part_q <= len_s >> LG;
        pat_q  <= pat_last_idx;
      end
      if (state_q == ST_CALC) begin
        en_q    <= calc_en_s;
        start_q <= calc_start_s;
        end_q   <= calc_end_s;
      end
      if (state_q == ST_REDUCE) begin
        o_match_q <= red_match_s;
        o_idx_q   <= red_idx_s;
      end
    end
  end

  assign busy         = busy_q;
  assign pe_valid     = pe_valid_q;
  assign pe_en        = en_q;
  assign pe_start_idx = start_q;
  assign pe_end_idx   = end_q;
  assign o_valid      = o_valid_q;
  assign o_match      = o_match_q;
  assign o_match_idx  = o_idx_q;

endmodule

// File: tb/tb_sme_dispatch_ctrl.sv
// Self-checking bench for sme_dispatch_ctrl: directed jobs plus randomized jobs
// checked against a plain-arithmetic reference of the range split and reduction.
module tb_sme_dispatch_ctrl;

  localparam int NP = 4;
  localparam int SA = 8;
  localparam int PA = 5;

  logic               clk = 1'b0;
  logic               reset, start, o_ready;
  logic [SA-1:0]      str_last_idx;
  logic [PA-1:0]      pat_last_idx;
  logic               busy, pe_valid, o_valid, o_match;
  logic [NP-1:0]      pe_en, pe_done, pe_match;
  logic [NP*SA-1:0]   pe_start_idx, pe_end_idx, pe_match_idx;
  logic [SA-1:0]      o_match_idx;
`ifdef SME_WATCHDOG_EN
  logic               o_timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int jd[NP];
  logic jm[NP];
  int ji[NP];

  always #5 clk = ~clk;

  sme_dispatch_ctrl #(
    .NUM_PE(NP), .STR_AW(SA), .PAT_AW(PA)
`ifdef SME_WATCHDOG_EN
    , .WDOG_CYC(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .str_last_idx(str_last_idx), .pat_last_idx(pat_last_idx),
    .busy(busy), .pe_valid(pe_valid), .pe_en(pe_en),
    .pe_start_idx(pe_start_idx), .pe_end_idx(pe_end_idx),
    .pe_done(pe_done), .pe_match(pe_match), .pe_match_idx(pe_match_idx),
    .o_valid(o_valid), .o_ready(o_ready), .o_match(o_match), .o_match_idx(o_match_idx)
`ifdef SME_WATCHDOG_EN
    , .o_timeout(o_timeout)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] xp);
    n_cmp++;
    assert (obs === xp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, xp);
    end
  endtask

  // Reference split: equal parts, overlap of pat_last, clipped to the string end.
  task automatic model_ranges(input int s, input int p, output logic [NP-1:0] en,
                              output logic [NP*SA-1:0] st, output logic [NP*SA-1:0] ev);
    int part, e;
    part = (s + 1) / NP;
    st = '0;
    ev = '0;
    if (part == 0) begin
      en = 4'b0001;
      ev[SA-1:0] = SA'(s);
    end else begin
      en = 4'b1111;
      for (int k = 0; k < NP; k++) begin
        e = (k + 1) * part - 1 + p;
        if (k == NP - 1 || e > s) e = s;
        st[k*SA +: SA] = SA'(k * part);
        ev[k*SA +: SA] = SA'(e);
      end
    end
  endtask

  task automatic run_job(input int s, input int p, input int hold, input bit start_in_hold);
    logic [NP-1:0]    xen;
    logic [NP*SA-1:0] xst, xev;
    logic             xm, xto;
    int               xi, last_c, n;
    model_ranges(s, p, xen, xst, xev);
    xm = 1'b0; xi = 0; last_c = 0; xto = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (xen[k] && jd[k] < 0) xto = 1'b1;
      if (xen[k] && jd[k] > last_c) last_c = jd[k];
      if (xen[k] && jd[k] >= 0 && jm[k] && (!xm || ji[k] < xi)) begin
        xm = 1'b1;
        xi = ji[k];
      end
    end
    str_last_idx = SA'(s);
    pat_last_idx = PA'(p);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("pe_valid_calc", 64'(pe_valid), 64'(0));
    chk("busy_calc", 64'(busy), 64'(1));
    step();
    chk("pe_valid_dispatch", 64'(pe_valid), 64'(1));
    chk("pe_en", 64'(pe_en), 64'(xen));
    chk("pe_start_idx", 64'(pe_start_idx), 64'(xst));
    chk("pe_end_idx", 64'(pe_end_idx), 64'(xev));
    for (int c = 0; c <= last_c; c++) begin
      for (int k = 0; k < NP; k++) begin
        pe_match_idx[k*SA +: SA] = SA'($urandom);
        pe_match[k] = 1'($urandom);
        if (xen[k] && jd[k] == c) begin
          pe_done[k] = 1'b1;
          pe_match[k] = jm[k];
          pe_match_idx[k*SA +: SA] = SA'(ji[k]);
        end else if ((!xen[k] || (jd[k] >= 0 && jd[k] < c)) && $urandom_range(0, 2) == 0) begin
          pe_done[k] = 1'b1;
        end else begin
          pe_done[k] = 1'b0;
        end
      end
      step();
      if (c == 0) chk("pe_valid_pulse", 64'(pe_valid), 64'(0));
    end
    pe_done = '0;
    n = 1;
    while (o_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    if (!xto) chk("o_valid_latency", 64'(n), 64'((last_c == 0) ? 3 : 2));
    chk("o_valid", 64'(o_valid), 64'(1));
    chk("o_match", 64'(o_match), 64'(xm));
    chk("o_match_idx", 64'(o_match_idx), 64'(xi));
`ifdef SME_WATCHDOG_EN
    chk("o_timeout", 64'(o_timeout), 64'(xto));
`endif
    for (int h = 0; h < hold; h++) begin
      if (start_in_hold && h == 1) start = 1'b1;
      step();
      start = 1'b0;
      chk("hold_o_valid", 64'(o_valid), 64'(1));
      chk("hold_o_match", 64'(o_match), 64'(xm));
      chk("hold_o_match_idx", 64'(o_match_idx), 64'(xi));
      chk("hold_pe_valid", 64'(pe_valid), 64'(0));
    end
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    chk("post_hs_o_valid", 64'(o_valid), 64'(0));
    chk("post_hs_busy", 64'(busy), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_pe_valid"}, 64'(pe_valid), 64'(0));
    chk({tag, "_pe_en"}, 64'(pe_en), 64'(0));
    chk({tag, "_start"}, 64'(pe_start_idx), 64'(0));
    chk({tag, "_end"}, 64'(pe_end_idx), 64'(0));
    chk({tag, "_o_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_o_match"}, 64'(o_match), 64'(0));
    chk({tag, "_o_match_idx"}, 64'(o_match_idx), 64'(0));
`ifdef SME_WATCHDOG_EN
    chk({tag, "_o_timeout"}, 64'(o_timeout), 64'(0));
`endif
  endtask

  task automatic set_pe(input int k, input int d, input logic m, input int ix);
    jd[k] = d;
    jm[k] = m;
    ji[k] = ix;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; o_ready = 1'b0;
    str_last_idx = '0; pat_last_idx = '0;
    pe_done = '0; pe_match = '0; pe_match_idx = '0;
    step();
    step();
    chk_zero("reset");
    reset = 1'b0;
    step();

    // Done order 3,1,0,2; matches on PE1 idx 7 and PE3 idx 16.
    set_pe(0, 3, 1'b0, 0); set_pe(1, 2, 1'b1, 7); set_pe(2, 4, 1'b0, 0); set_pe(3, 1, 1'b1, 16);
    run_job(19, 3, 0, 1'b0);
    // Remainder to last PE; tie on idx 6 between PE0 and PE1, all done during DISPATCH.
    set_pe(0, 0, 1'b1, 6); set_pe(1, 0, 1'b1, 6); set_pe(2, 0, 1'b0, 3); set_pe(3, 0, 1'b1, 9);
    run_job(21, 3, 0, 1'b0);
    // No PE matches.
    set_pe(0, 2, 1'b0, 11); set_pe(1, 1, 1'b0, 22); set_pe(2, 3, 1'b0, 33); set_pe(3, 2, 1'b0, 44);
    run_job(100, 10, 0, 1'b0);
    // Short string: PE0 only; garbage pulses on disabled PEs must be ignored.
    set_pe(0, 2, 1'b1, 1); set_pe(1, 0, 1'b1, 0); set_pe(2, 0, 1'b1, 0); set_pe(3, 0, 1'b1, 0);
    run_job(2, 3, 0, 1'b0);
    // Back-pressure for 5 cycles with a start pulse that must be ignored.
    set_pe(0, 1, 1'b0, 0); set_pe(1, 3, 1'b1, 30); set_pe(2, 2, 1'b1, 25); set_pe(3, 1, 1'b0, 0);
    run_job(50, 7, 5, 1'b1);

    // Reset while in WAIT with one result already captured.
    str_last_idx = 8'd40; pat_last_idx = 5'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    pe_done = 4'b0001; pe_match = 4'b0001; pe_match_idx = 32'h0000_0005;
    step();
    pe_done = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("mid_reset");

    for (int r = 0; r < 30; r++) begin
      int hold;
      for (int k = 0; k < NP; k++) begin
        set_pe(k, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
      end
      hold = $urandom_range(0, 3);
      run_job($urandom_range(0, 255), $urandom_range(0, 31), hold, hold > 1);
    end

`ifdef SME_WATCHDOG_EN
    // PE2 never reports: watchdog forces the result from the captured PEs.
    set_pe(0, 1, 1'b0, 0); set_pe(1, 2, 1'b1, 12); set_pe(2, -1, 1'b1, 1); set_pe(3, 1, 1'b0, 0);
    run_job(60, 4, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
